// File: rtl/barcode_lookup_table.sv
// Barcode-to-product-ID table with a sequential first-match scan.
// Define BARCODE_DEFAULT_TABLE_EN to load the factory codes on reset.
module barcode_lookup_table #(
  parameter  int DIGITS  = 4,
  parameter  int DIGIT_W = 4,
  parameter  int ENTRIES = 16,
  localparam int ID_W    = $clog2(ENTRIES),
  localparam int BW      = DIGITS * DIGIT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [ID_W-1:0] wr_index,
  input  logic [BW-1:0]   wr_barcode,
  input  logic            wr_valid,
  input  logic            lookup_req,
  input  logic [BW-1:0]   lookup_barcode,
  output logic            lookup_busy,
  output logic            result_valid,
  output logic            result_hit,
  output logic [ID_W-1:0] result_id
);

  typedef struct packed {
    logic          valid;
    logic [BW-1:0] code;
  } entry_t;

  typedef enum logic {
    IDLE,
    SEARCH
  } state_t;

  localparam logic [ID_W-1:0] LAST = ID_W'(ENTRIES - 1);

  if (ENTRIES < 2) begin : g_depth_check
    $error("barcode_lookup_table: ENTRIES must be >= 2");
  end

`ifdef BARCODE_DEFAULT_TABLE_EN
  if (DIGITS != 4 || DIGIT_W != 4 || ENTRIES < 12) begin : g_cfg_check
    $error("barcode_lookup_table: factory table needs 4x4-bit digits, >=12 entries");
  end
`endif

  function automatic entry_t rst_entry(input int i);
    entry_t e;
    e = '0;
`ifdef BARCODE_DEFAULT_TABLE_EN
    e.valid = (i < 12);
    case (i)
      0:       e.code = BW'(16'h3124);
      1:       e.code = BW'(16'h4132);
      2:       e.code = BW'(16'h4133);
      3:       e.code = BW'(16'h3121);
      4:       e.code = BW'(16'h3133);
      5:       e.code = BW'(16'h3214);
      6:       e.code = BW'(16'h2134);
      7:       e.code = BW'(16'h2144);
      8:       e.code = BW'(16'h3112);
      9:       e.code = BW'(16'h4321);
      10:      e.code = BW'(16'h1342);
      11:      e.code = BW'(16'h1213);
      default: e.code = '0;
    endcase
`else
    e.valid = (i < 0);
`endif
    return e;
  endfunction

  entry_t          tbl [ENTRIES];
  state_t          state;
  logic [BW-1:0]   key;
  logic [ID_W-1:0] idx;
  logic            wr_ok;
  logic            match;

  assign wr_ok = int'(wr_index) < ENTRIES;
  assign match = tbl[idx].valid && (tbl[idx].code == key);
  assign lookup_busy = (state == SEARCH);

  // Table writes land at the edge, so a scan sees them from the next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl[i] <= rst_entry(i);
      end
    end else if (wr_en && wr_ok) begin
      tbl[wr_index] <= '{valid: wr_valid, code: wr_barcode};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      key          <= '0;
      idx          <= '0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_id    <= '1;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (lookup_req) begin
            key   <= lookup_barcode;
            idx   <= '0;
            state <= SEARCH;
          end
        end
        SEARCH: begin
          if (match) begin
            result_valid <= 1'b1;
            result_hit   <= 1'b1;
            result_id    <= idx;
            state        <= IDLE;
          end else if (idx == LAST) begin
            result_valid <= 1'b1;
            result_hit   <= 1'b0;
            result_id    <= '1;
            state        <= IDLE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barcode_lookup_table.sv
// Directed bench for barcode_lookup_table (16 entries, 4x4-bit digits).
// Runs with or without BARCODE_DEFAULT_TABLE_EN.
module tb_barcode_lookup_table;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [3:0]  wr_index;
  logic [15:0] wr_barcode;
  logic        wr_valid;
  logic        lookup_req;
  logic [15:0] lookup_barcode;
  logic        lookup_busy;
  logic        result_valid;
  logic        result_hit;
  logic [3:0]  result_id;

  int nchecks = 0;
  int nerrors = 0;
  int lat;
  int bc;
  int pulses;

  logic [15:0] fac [12] = '{
    16'h3124, 16'h4132, 16'h4133, 16'h3121,
    16'h3133, 16'h3214, 16'h2134, 16'h2144,
    16'h3112, 16'h4321, 16'h1342, 16'h1213
  };

  barcode_lookup_table #(
    .DIGITS (4),
    .DIGIT_W(4),
    .ENTRIES(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_en         (wr_en),
    .wr_index      (wr_index),
    .wr_barcode    (wr_barcode),
    .wr_valid      (wr_valid),
    .lookup_req    (lookup_req),
    .lookup_barcode(lookup_barcode),
    .lookup_busy   (lookup_busy),
    .result_valid  (result_valid),
    .result_hit    (result_hit),
    .result_id     (result_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_entry(input logic [3:0] i, input logic [15:0] code,
                             input logic v);
    wr_en      = 1'b1;
    wr_index   = i;
    wr_barcode = code;
    wr_valid   = v;
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Issue a request at the current negedge; lat = cycles after acceptance
  task automatic lookup(input logic [15:0] code, output int l, output int b);
    lookup_barcode = code;
    lookup_req     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lookup_req = 1'b0;
    l = 1;
    b = 0;
    while (!result_valid && l < 40) begin
      if (lookup_busy) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic expect_lookup(input string tag, input logic [15:0] code,
                               input logic h, input logic [3:0] id,
                               input int elat);
    int l;
    int b;
    lookup(code, l, b);
    check({tag, "_lat"}, l, elat);
    check({tag, "_hit"}, result_hit, h);
    check({tag, "_id"}, result_id, id);
  endtask

  task automatic load_factory();
    for (int i = 0; i < 12; i++) begin
      write_entry(4'(i), fac[i], 1'b1);
    end
  endtask

  initial begin
    rst            = 1'b1;
    wr_en          = 1'b0;
    wr_index       = '0;
    wr_barcode     = '0;
    wr_valid       = 1'b0;
    lookup_req     = 1'b0;
    lookup_barcode = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", lookup_busy, 1'b0);
    check("rst_rv", result_valid, 1'b0);
    check("rst_hit", result_hit, 1'b0);
    check("rst_id", result_id, 4'hF);
    rst = 1'b0;
    @(negedge clk);

`ifndef BARCODE_DEFAULT_TABLE_EN
    expect_lookup("empty_miss", 16'h3124, 1'b0, 4'hF, 17);
    write_entry(4'd0, 16'h3124, 1'b1);
    expect_lookup("first_hit", 16'h3124, 1'b1, 4'h0, 2);
    load_factory();
`else
    expect_lookup("first_hit", 16'h3124, 1'b1, 4'h0, 2);
`endif

    lookup(16'h3214, lat, bc);
    check("h5_lat", lat, 7);
    check("h5_hit", result_hit, 1'b1);
    check("h5_id", result_id, 4'd5);
    check("h5_busy", bc, 6);
    check("h5_busy_low", lookup_busy, 1'b0);
    expect_lookup("h11", 16'h1213, 1'b1, 4'd11, 13);

    lookup(16'h9999, lat, bc);
    check("miss_lat", lat, 17);
    check("miss_hit", result_hit, 1'b0);
    check("miss_id", result_id, 4'hF);
    check("miss_busy", bc, 16);

    write_entry(4'd2, 16'h4321, 1'b1);
    expect_lookup("dup_low", 16'h4321, 1'b1, 4'd2, 4);
    write_entry(4'd2, 16'h4321, 1'b0);
    expect_lookup("dup_del", 16'h4321, 1'b1, 4'd9, 11);
    write_entry(4'd2, 16'h4133, 1'b1);

    // Write entry 3 in the cycle it is compared; stray request mid-scan
    lookup_barcode = 16'h1342;
    lookup_req     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lookup_req = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      wr_en          = (lat == 4);
      wr_index       = 4'd3;
      wr_barcode     = 16'h1342;
      wr_valid       = 1'b1;
      lookup_req     = (lat == 6);
      lookup_barcode = 16'h3124;
      @(negedge clk);
      lat++;
    end
    wr_en      = 1'b0;
    lookup_req = 1'b0;
    check("coll_lat", lat, 12);
    check("coll_hit", result_hit, 1'b1);
    check("coll_id", result_id, 4'd10);
    expect_lookup("b2b", 16'h1342, 1'b1, 4'd3, 5);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("no_extra", pulses, 0);
    write_entry(4'd3, 16'h3121, 1'b1);

    // Reset while entry 5 is being compared
    lookup_barcode = 16'h3214;
    lookup_req     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lookup_req = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_rst_busy", lookup_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_busy", lookup_busy, 1'b0);
    check("mrst_rv", result_valid, 1'b0);
    check("mrst_hit", result_hit, 1'b0);
    check("mrst_id", result_id, 4'hF);
    pulses = 0;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    check("mrst_nopulse", pulses, 0);

`ifdef BARCODE_DEFAULT_TABLE_EN
    expect_lookup("post_rst", 16'h1213, 1'b1, 4'd11, 13);
`else
    expect_lookup("post_rst_miss", 16'h1213, 1'b0, 4'hF, 17);
    load_factory();
    expect_lookup("post_rst", 16'h1213, 1'b1, 4'd11, 13);
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/barcode_lookup_table.md
# barcode_lookup_table

Programmable, parametrised barcode-to-product-ID lookup for the sale terminal. Holds a table of ENTRIES barcodes, each DIGITS digits of DIGIT_W bits, with a per-entry valid bit. A lookup request is scanned sequentially, one entry per cycle, and returns the index of the first matching valid entry as the product ID. It sits between the barcode controller, which supplies the scanned digits, and the price/cart logic, which consumes the ID. The table can be rewritten at run time by the operator/config path.

## Interface
- DIGITS, 4, digits per barcode
- DIGIT_W, 4, bits per digit
- ENTRIES, 16, table depth (>= 2); ID_W = $clog2(ENTRIES) derived localparam
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- wr_en  input  1  table write strobe
- wr_index  input  ID_W  entry to write
- wr_barcode  input  DIGITS*DIGIT_W  barcode to store; digit 0 in LSBs
- wr_valid  input  1  valid bit stored with entry (0 = delete entry)
- lookup_req  input  1  start lookup; accepted only when lookup_busy = 0
- lookup_barcode  input  DIGITS*DIGIT_W  barcode to search, sampled on acceptance
- lookup_busy  output  1  scan in progress
- result_valid  output  1  one-cycle pulse: result fields updated
- result_hit  output  1  1 = match found
- result_id  output  ID_W  matching index on hit; all ones on miss

## Operation
- States: IDLE, SEARCH. lookup_busy = (state == SEARCH).
- IDLE: on lookup_req, latch lookup_barcode into key register, clear scan index to 0, go to SEARCH. lookup_req while busy is ignored (not queued).
- SEARCH: each cycle compare key against entry[index], match = entry valid and all DIGITS*DIGIT_W bits equal.
  - Match: result_hit = 1, result_id = index, pulse result_valid, go to IDLE.
  - No match, index = ENTRIES-1: result_hit = 0, result_id = all ones, pulse result_valid, go to IDLE.
  - Otherwise index + 1.
- First match wins: duplicate barcodes resolve to the lowest index.
- Writes accepted in any state, every cycle; entry updated at the clock edge of wr_en. wr_index >= ENTRIES is ignored.
- Write/scan collision: a write in cycle t is visible to comparisons from cycle t+1; the comparison in cycle t uses the old contents.
- result_hit and result_id hold their value between result_valid pulses.
- Reset (any time, including mid-scan): state IDLE, lookup_busy 0, result_valid 0, result_hit 0, result_id all ones, key 0, index 0, table per Configuration. An in-flight scan is abandoned with no result pulse.

## Timing
- lookup_req accepted in cycle t: lookup_busy high from t+1. Entry i compared in cycle t+1+i.
- Hit at index i: result_valid high in cycle t+2+i, lookup_busy low in the same cycle.
- Miss: result_valid in cycle t+1+ENTRIES.
- Back-to-back: a lookup_req in the result_valid cycle is accepted (state is IDLE). Peak rate is one lookup per i+2 cycles.
- All outputs registered. There is no combinational path from inputs to outputs.

## Configuration
- BARCODE_DEFAULT_TABLE_EN defined: on reset, entries 0..11 load the factory codes 3124, 4132, 4133, 3121, 3133, 3214, 2134, 2144, 3112, 4321, 1342, 1213. Codes are hex-packed digit3..digit0. These entries are valid; all other entries are invalid with zero data.
  - The macro requires DIGITS = 4, DIGIT_W = 4 and ENTRIES >= 12. Any other combination is a compile-time error via a generate-time check.
- Macro undefined: reset clears every valid bit and all entry data. The table must be written before any hit is possible.

## Test plan
- Default table (macro on), lookup 16'h3214 -> result_valid at t+7, result_hit = 1, result_id = 5. Lookup 16'h1213 -> result_id = 11.
- Lookup 16'h9999 with 16 entries -> result_valid at t+17, result_hit = 0, result_id = 4'hF. lookup_busy is high for exactly 16 cycles.
- Duplicates: write 16'h4321 at index 2 with valid = 1, then lookup 16'h4321 -> result_id = 2, not 9. Then write index 2 with valid = 0, lookup again -> result_id = 9.
- Collision and ignored request: start a lookup of 16'h1342. In the cycle entry 3 is compared, write 16'h1342 to index 3 -> hit at index 10. A lookup_req issued mid-scan produces no extra result. A request in the result_valid cycle starts the next scan.
- Reset at scan index 5 -> no result_valid. Outputs are at reset values the cycle after rst asserts. After release, a new lookup works normally.
- Macro off: after reset, lookup 16'h3124 -> miss. Write index 0 = 16'h3124 -> subsequent lookup hits with result_id = 0 at t+2.
